// File: rtl/uart_echo_sched_if.sv
// FIFO-side handshake bundle for the echo scheduler: RX pop port and TX push port.
// master = scheduler side, slave = UART core FIFO side.
interface uart_echo_sched_if;
   logic       rx_empty;
   logic [7:0] rd_data;
   logic       rd_uart;
   logic       tx_full;
   logic       wr_uart;
   logic [7:0] wr_data;

   modport master (
      input  rx_empty, rd_data, tx_full,
      output rd_uart, wr_uart, wr_data
   );

   modport slave (
      output rx_empty, rd_data, tx_full,
      input  rd_uart, wr_uart, wr_data
   );
endinterface

// File: rtl/uart_echo_sched.sv
// Autonomous echo scheduler: pops RX bytes, adds INC, pushes to TX, optionally appends LF after CR.
// Counts every TX push (including inserted LFs) in a wrapping counter.
module uart_echo_sched #(
   parameter logic [7:0]  INC       = 8'd1,
   parameter bit          LF_INSERT = 1'b1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   uart_echo_sched_if.master      bus,
   output logic                   busy,
   output logic [CNT_W-1:0]       echo_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      POP,
      WAIT_TX,
      PUSH,
      LF_WAIT,
      LF_PUSH
   } state_t;

   state_t     state;
   logic [7:0] byte_q;
   logic       cr_q;

   // Strobes and busy are registered alongside the state transition, so each
   // is an exact decode of the state it accompanies.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         byte_q      <= '0;
         cr_q        <= 1'b0;
         bus.rd_uart <= 1'b0;
         bus.wr_uart <= 1'b0;
         bus.wr_data <= '0;
         busy        <= 1'b0;
         echo_cnt    <= '0;
      end else begin
         bus.rd_uart <= 1'b0;
         bus.wr_uart <= 1'b0;
         case (state)
            IDLE: begin
               if (en && !bus.rx_empty) begin
                  byte_q      <= bus.rd_data;
                  cr_q        <= (bus.rd_data == 8'h0D);
                  bus.rd_uart <= 1'b1;
                  busy        <= 1'b1;
                  state       <= POP;
               end
            end
            POP: begin
               state <= WAIT_TX;
            end
            WAIT_TX: begin
               if (!bus.tx_full) begin
                  bus.wr_data <= byte_q + INC;
                  bus.wr_uart <= 1'b1;
                  state       <= PUSH;
               end
            end
            PUSH: begin
               echo_cnt <= echo_cnt + CNT_W'(1);
               if (LF_INSERT && cr_q) begin
                  state <= LF_WAIT;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            LF_WAIT: begin
               if (!bus.tx_full) begin
                  bus.wr_data <= 8'h0A;
                  bus.wr_uart <= 1'b1;
                  state       <= LF_PUSH;
               end
            end
            LF_PUSH: begin
               echo_cnt <= echo_cnt + CNT_W'(1);
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
      bus.wr_uart |-> !bus.tx_full);

   a_pop_only_when_seen: assert property (@(posedge clk) disable iff (rst)
      bus.rd_uart |-> $past(state == IDLE && !bus.rx_empty));

endmodule

// File: tb/tb_uart_echo_sched.sv
// Self-checking bench for uart_echo_sched: directed table, multi-cycle corner sequences,
// and a randomized run checked against a queue-based echo model.
module tb_uart_echo_sched;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b0;
   logic en_aux = 1'b0;
   always #5 clk = ~clk;

   uart_echo_sched_if m_if ();
   uart_echo_sched_if a_if ();
   uart_echo_sched_if f_if ();

   logic        busy, a_busy, f_busy;
   logic [15:0] cnt, f_cnt;
   logic [2:0]  a_cnt;

   uart_echo_sched #(.INC(8'd1), .LF_INSERT(1'b1), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .en(en), .bus(m_if.master), .busy(busy), .echo_cnt(cnt));
   uart_echo_sched #(.INC(8'd1), .LF_INSERT(1'b0), .CNT_W(3)) dut_nolf (
      .clk(clk), .rst(rst), .en(en_aux), .bus(a_if.master), .busy(a_busy), .echo_cnt(a_cnt));
   uart_echo_sched #(.INC(8'hF3), .LF_INSERT(1'b1), .CNT_W(16)) dut_f3 (
      .clk(clk), .rst(rst), .en(en_aux), .bus(f_if.master), .busy(f_busy), .echo_cnt(f_cnt));

   logic [7:0] rx_q[$];
   logic [7:0] tx_got[$];
   logic [7:0] a_got[$];
   logic [7:0] f_got[$];
   int         rd_cyc[$];
   int         wr_cyc[$];
   int         cyc = 0;
   int         rd_cnt = 0;
   int         n_cmp = 0;
   int         n_bad = 0;

   // RX FIFO model: head presented first-word-fall-through, refreshed on the falling edge.
   always @(negedge clk) begin
      m_if.rx_empty = (rx_q.size() == 0);
      m_if.rd_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
      a_if.rx_empty = m_if.rx_empty;
      a_if.rd_data  = m_if.rd_data;
      f_if.rx_empty = m_if.rx_empty;
      f_if.rd_data  = m_if.rd_data;
   end

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (m_if.rd_uart) begin
         rd_cnt = rd_cnt + 1;
         rd_cyc.push_back(cyc);
         if (rx_q.size() != 0) void'(rx_q.pop_front());
      end
      if (m_if.wr_uart) begin
         tx_got.push_back(m_if.wr_data);
         wr_cyc.push_back(cyc);
      end
      if (a_if.wr_uart) a_got.push_back(a_if.wr_data);
      if (f_if.wr_uart) f_got.push_back(f_if.wr_data);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   function automatic logic [7:0] at(input logic [7:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 8'hxx;
   endfunction

   typedef struct {
      logic [7:0] rx;
      int         n;
      logic [7:0] e0;
      logic [7:0] e1;
      logic [7:0] f0;
   } vec_t;
   vec_t vt[8];

   initial begin
      int t0, r0, first_bad;
      logic [15:0] c0;
      logic [7:0] exp_q[$];
      logic [7:0] b;
      int pushed;

      m_if.tx_full = 1'b0;
      a_if.tx_full = 1'b0;
      f_if.tx_full = 1'b0;

      vt[0] = '{8'h41, 1, 8'h42, 8'h00, 8'h34};
      vt[1] = '{8'h0D, 2, 8'h0E, 8'h0A, 8'h00};
      vt[2] = '{8'hFF, 1, 8'h00, 8'h00, 8'hF2};
      vt[3] = '{8'h00, 1, 8'h01, 8'h00, 8'hF3};
      vt[4] = '{8'h0C, 1, 8'h0D, 8'h00, 8'hFF};
      vt[5] = '{8'h0E, 1, 8'h0F, 8'h00, 8'h01};
      vt[6] = '{8'h0A, 1, 8'h0B, 8'h00, 8'hFD};
      vt[7] = '{8'h7F, 1, 8'h80, 8'h00, 8'h72};

      tick(3);
      chk("rst_busy", busy, 0);
      chk("rst_rd_uart", m_if.rd_uart, 0);
      chk("rst_wr_uart", m_if.wr_uart, 0);
      chk("rst_wr_data", m_if.wr_data, 0);
      chk("rst_echo_cnt", cnt, 0);
      rst = 1'b0;
      en = 1'b1;
      en_aux = 1'b1;
      tick(2);

      for (int i = 0; i < 8; i++) begin
         tx_got.delete(); a_got.delete(); f_got.delete();
         rx_q.push_back(vt[i].rx);
         for (int k = 0; k < 40; k++) begin
            tick(1);
            if (tx_got.size() >= vt[i].n && !busy && !a_busy && !f_busy) break;
         end
         chk("tbl_main_n", tx_got.size(), vt[i].n);
         chk("tbl_main_b0", at(tx_got, 0), vt[i].e0);
         if (vt[i].n == 2) begin
            chk("tbl_main_lf", at(tx_got, 1), vt[i].e1);
            chk("tbl_f3_lf", at(f_got, 1), 8'h0A);
         end
         chk("tbl_nolf_n", a_got.size(), 1);
         chk("tbl_nolf_b0", at(a_got, 0), vt[i].e0);
         chk("tbl_f3_n", f_got.size(), vt[i].n);
         chk("tbl_f3_b0", at(f_got, 0), vt[i].f0);
         chk("tbl_nolf_cnt", a_cnt, (i + 1) % 8);
      end
      en_aux = 1'b0;
      chk("tbl_main_cnt", cnt, 9);
      chk("tbl_f3_cnt", f_cnt, 9);

      // Latency: pop two cycles after the byte appears, push two cycles after the pop.
      tx_got.delete(); rd_cyc.delete(); wr_cyc.delete();
      rx_q.push_back(8'h41);
      t0 = cyc;
      tick(10);
      chk("lat_pops", rd_cyc.size(), 1);
      chk("lat_pushes", wr_cyc.size(), 1);
      chk("lat_rd", (rd_cyc.size() > 0) ? rd_cyc[0] - t0 : -1, 2);
      chk("lat_wr", (wr_cyc.size() > 0) ? wr_cyc[0] - t0 : -1, 4);
      chk("lat_data", at(tx_got, 0), 8'h42);
      chk("lat_cnt", cnt, 10);

      // Burst with wrap: back-to-back bytes every 4 cycles.
      tx_got.delete(); rd_cyc.delete(); wr_cyc.delete();
      rx_q.push_back(8'hFE); rx_q.push_back(8'hFF); rx_q.push_back(8'h00);
      tick(20);
      chk("burst_n", tx_got.size(), 3);
      chk("burst_b0", at(tx_got, 0), 8'hFF);
      chk("burst_b1", at(tx_got, 1), 8'h00);
      chk("burst_b2", at(tx_got, 2), 8'h01);
      chk("burst_gap1", (wr_cyc.size() > 2) ? wr_cyc[1] - wr_cyc[0] : -1, 4);
      chk("burst_gap2", (wr_cyc.size() > 2) ? wr_cyc[2] - wr_cyc[1] : -1, 4);
      chk("burst_rdgap", (rd_cyc.size() > 2) ? rd_cyc[2] - rd_cyc[1] : -1, 4);

      // Backpressure: TX full holds the scheduler in WAIT_TX without further pops.
      tx_got.delete(); wr_cyc.delete();
      m_if.tx_full = 1'b1;
      r0 = rd_cnt;
      rx_q.push_back(8'h30); rx_q.push_back(8'h55);
      tick(22);
      chk("bp_no_push", tx_got.size(), 0);
      chk("bp_busy", busy, 1);
      chk("bp_one_pop", rd_cnt - r0, 1);
      chk("bp_rx_left", rx_q.size(), 1);
      m_if.tx_full = 1'b0;
      t0 = cyc;
      tick(12);
      chk("bp_rel_lat", (wr_cyc.size() > 0) ? wr_cyc[0] - t0 : -1, 2);
      chk("bp_b0", at(tx_got, 0), 8'h31);
      chk("bp_b1", at(tx_got, 1), 8'h56);

      // en dropped during the POP of a CR: CR echo and LF complete, next byte stays queued.
      tx_got.delete();
      r0 = rd_cnt;
      rx_q.push_back(8'h0D); rx_q.push_back(8'h41);
      for (int k = 0; k < 10; k++) begin
         tick(1);
         if (m_if.rd_uart) break;
      end
      en = 1'b0;
      tick(15);
      chk("en_n", tx_got.size(), 2);
      chk("en_b0", at(tx_got, 0), 8'h0E);
      chk("en_lf", at(tx_got, 1), 8'h0A);
      chk("en_held", rx_q.size(), 1);
      chk("en_pops", rd_cnt - r0, 1);
      chk("en_idle", busy, 0);
      en = 1'b1;
      tick(10);
      chk("en_resume", at(tx_got, 2), 8'h42);

      // Asynchronous reset in WAIT_TX discards the popped byte.
      tx_got.delete();
      m_if.tx_full = 1'b1;
      rx_q.push_back(8'h77);
      tick(4);
      chk("ar_busy_pre", busy, 1);
      #1 rst = 1'b1;
      #1;
      chk("ar_busy", busy, 0);
      chk("ar_rd", m_if.rd_uart, 0);
      chk("ar_wr", m_if.wr_uart, 0);
      chk("ar_wr_data", m_if.wr_data, 0);
      chk("ar_cnt", cnt, 0);
      m_if.tx_full = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(10);
      chk("ar_discard", tx_got.size(), 0);
      chk("ar_rx_empty", rx_q.size(), 0);

      // Randomized run against a queue-level echo model.
      tx_got.delete();
      exp_q.delete();
      c0 = cnt;
      r0 = rd_cnt;
      pushed = 0;
      for (int k = 0; k < 4000 && pushed < 150; k++) begin
         if ($urandom_range(0, 2) == 0) begin
            b = ($urandom_range(0, 5) == 0) ? 8'h0D : 8'($urandom_range(0, 255));
            rx_q.push_back(b);
            exp_q.push_back(8'(b + 8'd1));
            if (b == 8'h0D) exp_q.push_back(8'h0A);
            pushed++;
         end
         if (!m_if.wr_uart) m_if.tx_full = ($urandom_range(0, 4) == 0);
         en = ($urandom_range(0, 9) != 0);
         tick(1);
      end
      en = 1'b1;
      m_if.tx_full = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         tick(1);
         if (rx_q.size() == 0 && !busy) break;
      end
      first_bad = -1;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (first_bad < 0 && at(tx_got, i) !== exp_q[i]) first_bad = i;
      end
      chk("rand_len", tx_got.size(), exp_q.size());
      chk("rand_first_bad_idx", first_bad, -1);
      chk("rand_pops", rd_cnt - r0, pushed);
      chk("rand_cnt", 16'(cnt - c0), 16'(exp_q.size()));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
